// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory line arbiter.
// Holds the FSM encoding, the requester port indices and the default line geometry.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WB   = 3'd1,
        GAP  = 3'd2,
        RD   = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic PORT_D = 1'b0;
    localparam logic PORT_I = 1'b1;

    localparam int unsigned DEF_LINE_W   = 512;
    localparam int unsigned DEF_OFFSET_W = 6;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone request wins outright, a tie goes to the
// port that was not granted last. Purely combinational; the history bit lives in the parent.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    always_comb begin
        gnt_valid = |req;
        gnt_idx   = PORT_D;
        if (req == 2'b11) begin
            gnt_idx = ~last_grant;
        end else if (req[PORT_I]) begin
            gnt_idx = PORT_I;
        end
    end

endmodule

// File: rtl/mem_line_arbiter.sv
// Shares one line-wide memory port between the dcache (writeback + refill) and the ifetch refill path.
// Optional memory no-ack timeout is built only when MEM_TIMEOUT_EN is defined.
module mem_line_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned LINE_W         = DEF_LINE_W,
    parameter int unsigned OFFSET_W       = DEF_OFFSET_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              d_req,
    input  logic              d_evict,
    input  logic [ADDR_W-1:0] d_evict_addr,
    input  logic [LINE_W-1:0] d_evict_data,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_done,
    output logic [LINE_W-1:0] d_line,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_done,
    output logic [LINE_W-1:0] i_line,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              o_err
);

    localparam logic [OFFSET_W-1:0] OFF_ZERO = '0;

    state_t            state;
    logic              grant;
    logic              last_grant;
    logic [ADDR_W-1:0] rd_addr;
    logic              pick_valid;
    logic              pick_idx;
    logic [ADDR_W-1:0] pick_addr;
    logic              timeout_hit;

    // Offset bits of the request addresses never reach memory.
    logic unused_offsets;
    assign unused_offsets = ^{d_addr[OFFSET_W-1:0], i_addr[OFFSET_W-1:0], d_evict_addr[OFFSET_W-1:0]};

    rr_arbiter2 u_rr (
        .req        ({i_req, d_req}),
        .last_grant (last_grant),
        .gnt_valid  (pick_valid),
        .gnt_idx    (pick_idx)
    );

    always_comb begin
        pick_addr = {d_addr[ADDR_W-1:OFFSET_W], OFF_ZERO};
        if (pick_idx == PORT_I) begin
            pick_addr = {i_addr[ADDR_W-1:OFFSET_W], OFF_ZERO};
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] to_cnt;
    logic             waiting;

    assign waiting     = ((state == WB) || (state == RD)) && !mem_ack;
    assign timeout_hit = waiting && (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Cleared in every non-waiting state, so each WB/RD entry starts from zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (waiting && !timeout_hit) begin
            to_cnt <= to_cnt + CNT_W'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= PORT_D;
            last_grant <= PORT_I;
            rd_addr    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            d_done     <= 1'b0;
            i_done     <= 1'b0;
            d_line     <= '0;
            i_line     <= '0;
            busy       <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            d_done <= 1'b0;
            i_done <= 1'b0;
            o_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant      <= pick_idx;
                        last_grant <= pick_idx;
                        rd_addr    <= pick_addr;
                        busy       <= 1'b1;
                        mem_req    <= 1'b1;
                        if ((pick_idx == PORT_D) && d_evict) begin
                            state     <= WB;
                            mem_we    <= 1'b1;
                            mem_addr  <= {d_evict_addr[ADDR_W-1:OFFSET_W], OFF_ZERO};
                            mem_wdata <= d_evict_data;
                        end else begin
                            state     <= RD;
                            mem_we    <= 1'b0;
                            mem_addr  <= pick_addr;
                            mem_wdata <= '0;
                        end
                    end
                end
                WB: begin
                    if (timeout_hit) begin
                        // A failed writeback abandons the refill entirely.
                        state     <= RESP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        d_done    <= (grant == PORT_D);
                        i_done    <= (grant == PORT_I);
                        o_err     <= 1'b1;
                    end else if (mem_ack) begin
                        state     <= GAP;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                    end
                end
                GAP: begin
                    state    <= RD;
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= rd_addr;
                end
                RD: begin
                    if (timeout_hit) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        d_done  <= (grant == PORT_D);
                        i_done  <= (grant == PORT_I);
                        o_err   <= 1'b1;
                    end else if (mem_ack) begin
                        state   <= RESP;
                        mem_req <= 1'b0;
                        if (grant == PORT_I) begin
                            i_line <= mem_rdata;
                            i_done <= 1'b1;
                        end else begin
                            d_line <= mem_rdata;
                            d_done <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mem_line_arbiter.md
Name: mem_line_arbiter

Overview:
Shares one 512-bit-line backing-memory port between the data cache (sa_cache miss/evict side) and the instruction fetch line refill path. Grants round-robin and sequences a dirty-line writeback followed by a refill as one locked transaction for the data cache. Sits between the cache miss interfaces and main memory. Completes one memory transaction at a time.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 512, cache line width in bits
OFFSET_W, 6, line offset bits; forced to zero on mem_addr
TIMEOUT_CYCLES, 1024, memory no-ack limit (used only with MEM_TIMEOUT_EN)

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-low reset
d_req  in  1  data cache miss request; held until d_done
d_evict  in  1  write back the dirty line before refill
d_evict_addr  in  ADDR_W  victim line address
d_evict_data  in  LINE_W  victim line data
d_addr  in  ADDR_W  refill address
d_done  out  1  one-cycle completion pulse
d_line  out  LINE_W  refill data; valid while d_done is high, then held
i_req  in  1  instruction line request; held until i_done
i_addr  in  ADDR_W  instruction refill address
i_done  out  1  one-cycle completion pulse
i_line  out  LINE_W  refill data; valid while i_done is high, then held
mem_req  out  1  memory request
mem_we  out  1  1 = line write, 0 = line read
mem_addr  out  ADDR_W  line-aligned address
mem_wdata  out  LINE_W  write data
mem_ack  in  1  transaction complete; for a read, mem_rdata is valid this cycle
mem_rdata  in  LINE_W  read line
busy  out  1  high whenever state is not IDLE
o_err  out  1  timeout error pulse

Behaviour:
- All outputs are registered. Reset value of every output is 0, lines included. last_grant resets to icache.
- FSM: IDLE -> (grant) WB if d_evict, else RD. WB -(mem_ack)-> GAP -> RD -(mem_ack)-> RESP -> IDLE.
- IDLE arbitration:
  - If only one req is high, that port is granted.
  - If both are high, the port other than last_grant is granted. After reset, dcache therefore wins the first tie.
  - Request fields are captured at grant. last_grant is updated at grant.
- WB: mem_req=1, mem_we=1, mem_addr={d_evict_addr[ADDR_W-1:OFFSET_W], 0}, mem_wdata=d_evict_data.
- GAP: mem_req=0 for exactly one cycle.
- RD: mem_req=1, mem_we=0, mem_addr = the granted port's address with low OFFSET_W bits zero. mem_wdata = 0.
- mem_req, mem_we, mem_addr and mem_wdata are stable from assertion until the mem_ack cycle. mem_ack sampled while mem_req=0 is ignored.
- Read latency from mem_ack:
  - On the mem_ack edge in RD, mem_rdata is latched into the granted port's line register.
  - The granted port's done pulses for the RESP cycle.
  - The other port's line register is untouched.
- Minimum read latency, no evict:
  - req sampled at edge E0 -> mem_req high after E0.
  - mem_ack at E1 -> done high after E1.
  - IDLE after E2; the next grant can be sampled at E3.
- Requester rules:
  - The requester keeps req and its fields stable until it samples done.
  - If req drops early, the transaction still completes and done still pulses.
  - req is not sampled in WB, GAP, RD or RESP.
- Reset mid-operation: FSM returns to IDLE and mem_req drops immediately (asynchronous). No done pulse is issued. The memory must tolerate the abandoned request.

Optional Feature:
MEM_TIMEOUT_EN
- Defined:
  - A counter runs while in WB or RD and clears on state entry.
  - When the counter reaches TIMEOUT_CYCLES without mem_ack, mem_req drops and the FSM goes to RESP.
  - o_err pulses together with the granted port's done. The line register is not updated.
  - A timeout in WB skips the refill.
- Not defined: no counter is built; the FSM waits indefinitely; o_err is tied to 0.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum: IDLE, WB, GAP, RD, RESP
  - port index constants: PORT_D=0, PORT_I=1
  - default LINE_W and OFFSET_W
- One sub-module, rr_arbiter2: 2-way round-robin pick from (req[1:0], last_grant). It is combinational, with the last_grant register kept in the parent.

Test Plan:
- i_req with i_addr=0x0000_1234; mem_ack one cycle after mem_req; mem_rdata={16{32'hA5A5_0001}} -> mem_addr=0x0000_1200, mem_we=0; i_done is a 1-cycle pulse; i_line equals that data; d_line stays 0.
- d_req with d_evict=1, d_evict_addr=0x0000_8047, d_evict_data={16{32'hDEAD_BEEF}}, d_addr=0x0000_2010 -> write to 0x8040 with that data; mem_req low for exactly 1 cycle; read at 0x2000; single d_done.
- d_req and i_req both high after reset, held -> dcache served first, then icache. Repeat the simultaneous request -> dcache again (alternation). busy stays high throughout each transaction.
- mem_ack delayed 5 cycles in RD -> mem_req, mem_addr and mem_we constant for all 6 cycles; done pulses exactly once, one cycle after ack.
- rst driven low 2 cycles into RD -> mem_req=0 and busy=0 immediately; no done pulse; a late mem_ack after reset has no effect.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES=16, d_req and no mem_ack -> mem_req drops after 16 cycles; o_err and d_done pulse together; d_line unchanged.
